// File: rtl/rc5_if.sv
`default_nettype none
// ============================================================================
//  Module   : rc5_if
//  Purpose  : Block handshake bundle between a block source and the RC5 decryptor.
//  Revision : 1.0  initial release
// ============================================================================
interface rc5_if #(
    parameter int W = 32
);
    logic [2*W-1:0] din;
    logic           di_vld;
    logic [2*W-1:0] dout;
    logic           do_vld;
    logic           busy;

    modport master (
        output din,
        output di_vld,
        input  dout,
        input  do_vld,
        input  busy
    );

    modport slave (
        input  din,
        input  di_vld,
        output dout,
        output do_vld,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/rc5_decrypt.sv
`default_nettype none
// ============================================================================
//  Module   : rc5_decrypt
//  Purpose  : RC5-32/12 block decryptor, one inverse round per clock.
//  Revision : 1.0  initial release
// ============================================================================
module rc5_decrypt #(
    parameter int W      = 32,
    parameter int ROUNDS = 12
) (
    input  wire logic clk,
    input  wire logic clr,
    rc5_if.slave      bus
);
    localparam int CW = $clog2(ROUNDS + 1);
    localparam int RW = $clog2(W);

    // Expanded key table shared with the encryptor on the transmit side.
    localparam logic [W-1:0] C_SKEY [0:2*ROUNDS+1] = '{
        32'h9BBBD8C8, 32'h1A37F7FB, 32'h46F8E8C5, 32'h460C6085, 32'h70F83B8A,
        32'h284B8303, 32'h513E1454, 32'hF621ED22, 32'h3125065D, 32'h11A83A5D,
        32'hD427686B, 32'h713AD82D, 32'h4B792F99, 32'h2799A4DD, 32'hA7901C49,
        32'hDEDE871A, 32'h36C03196, 32'hA7EFC249, 32'h61A78BB8, 32'h3B0A1D2B,
        32'h4DBFCA76, 32'hAE162167, 32'h30D76B0A, 32'h43192304, 32'hF6CC1431,
        32'h65046380
    };

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ROUND_OP   = 2'd1,
        ST_POST_ROUND = 2'd2,
        ST_READY      = 2'd3
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [CW-1:0]   r_i_cnt;
    logic [2*W-1:0]  r_dout;
    logic            r_do_vld;
    logic            r_busy;

    logic [CW:0]     w_idx_a;
    logic [CW:0]     w_idx_b;
    logic [W-1:0]    w_b_nxt;
    logic [W-1:0]    w_a_nxt;

    // Rotating the doubled word avoids a shift-by-W term when the amount is 0.
    function automatic logic [W-1:0] ror(input logic [W-1:0] x, input logic [RW-1:0] n);
        logic [2*W-1:0] dbl;
        dbl = {x, x} >> n;
        return dbl[W-1:0];
    endfunction

    assign w_idx_a = {r_i_cnt, 1'b0};
    assign w_idx_b = {r_i_cnt, 1'b1};
    assign w_b_nxt = ror(r_b - C_SKEY[w_idx_b], r_a[RW-1:0]) ^ r_a;
    assign w_a_nxt = ror(r_a - C_SKEY[w_idx_a], w_b_nxt[RW-1:0]) ^ w_b_nxt;

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_i_cnt  <= '0;
            r_dout   <= '0;
            r_do_vld <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_READY: begin
                    if (bus.di_vld) begin
                        r_a      <= bus.din[2*W-1:W];
                        r_b      <= bus.din[W-1:0];
                        r_i_cnt  <= CW'(ROUNDS);
                        r_busy   <= 1'b1;
                        r_do_vld <= 1'b0;
                        r_state  <= ST_ROUND_OP;
                    end
                end
                ST_ROUND_OP: begin
                    r_b     <= w_b_nxt;
                    r_a     <= w_a_nxt;
                    r_i_cnt <= r_i_cnt - CW'(1);
                    if (r_i_cnt == CW'(1)) begin
                        r_state <= ST_POST_ROUND;
                    end
                end
                ST_POST_ROUND: begin
                    r_a      <= r_a - C_SKEY[0];
                    r_b      <= r_b - C_SKEY[1];
                    r_dout   <= {r_a - C_SKEY[0], r_b - C_SKEY[1]};
                    r_do_vld <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_READY;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.dout   = r_dout;
    assign bus.do_vld = r_do_vld;
    assign bus.busy   = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_rc5_decrypt.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_rc5_decrypt
//  Purpose  : Scoreboard bench for rc5_decrypt using directed and round-trip blocks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rc5_decrypt;
    localparam logic [63:0] C_T2_CT = 64'hEEDBA5216D8F4B15;

    localparam logic [31:0] C_SKEY [0:25] = '{
        32'h9BBBD8C8, 32'h1A37F7FB, 32'h46F8E8C5, 32'h460C6085, 32'h70F83B8A,
        32'h284B8303, 32'h513E1454, 32'hF621ED22, 32'h3125065D, 32'h11A83A5D,
        32'hD427686B, 32'h713AD82D, 32'h4B792F99, 32'h2799A4DD, 32'hA7901C49,
        32'hDEDE871A, 32'h36C03196, 32'hA7EFC249, 32'h61A78BB8, 32'h3B0A1D2B,
        32'h4DBFCA76, 32'hAE162167, 32'h30D76B0A, 32'h43192304, 32'hF6CC1431,
        32'h65046380
    };

    typedef struct {
        logic [63:0] pt;
        int          acc;
    } exp_t;

    logic clk;
    logic clr;
    int   cyc;
    int   total;
    int   bad;
    exp_t exp_q[$];
    logic prev_vld;

    rc5_if #(.W(32)) bus ();

    rc5_decrypt #(.W(32), .ROUNDS(12)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] n);
        if (n == 5'd0) return x;
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

    // Forward RC5-32/12 encryptor, the independent reference for round trips.
    function automatic logic [63:0] enc(input logic [63:0] p);
        logic [31:0] a, b;
        a = p[63:32] + C_SKEY[0];
        b = p[31:0] + C_SKEY[1];
        for (int i = 1; i <= 12; i++) begin
            a = rol(a ^ b, b[4:0]) + C_SKEY[2*i];
            b = rol(b ^ a, a[4:0]) + C_SKEY[2*i+1];
        end
        return {a, b};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at cycle %0d", name, act, want, cyc);
        end
    endtask

    // Issue one block; sync=0 drives it in the current cycle (already at a negedge).
    task automatic send(input logic [63:0] ct, input logic [63:0] pt, input bit sync, input bit push);
        exp_t e;
        if (sync) @(negedge clk);
        bus.din    = ct;
        bus.di_vld = 1'b1;
        @(posedge clk);
        #1;
        bus.di_vld = 1'b0;
        if (push) begin
            e.pt  = pt;
            e.acc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_vld(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.do_vld) seen = 1'b1;
        end
        check({name, "_timeout"}, 64'(seen), 64'd1);
    endtask

    // Scoreboard monitor: every new result must match the oldest issued block.
    always @(negedge clk) begin
        if (bus.do_vld && !prev_vld) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", bus.dout, 64'hX);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", bus.dout, e.pt);
                check("latency", 64'(cyc - e.acc), 64'd13);
            end
        end
        prev_vld = bus.do_vld;
    end

    initial begin
        logic [63:0] pt, pt2;
        total      = 0;
        bad        = 0;
        prev_vld   = 1'b0;
        clr        = 1'b0;
        bus.din    = C_T2_CT;
        bus.di_vld = 1'b1;

        // T1: reset wins over a simultaneous block
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dout", bus.dout, 64'd0);
        check("rst_do_vld", 64'(bus.do_vld), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        bus.di_vld = 1'b0;
        clr        = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_accept_busy", 64'(bus.busy), 64'd0);

        // T2: standard all-zero-key vector
        send(C_T2_CT, 64'd0, 1'b1, 1'b1);
        wait_vld("t2");

        // T3: round trips including rotate-by-zero cases arising at random
        send(enc(64'h0123456789ABCDEF), 64'h0123456789ABCDEF, 1'b1, 1'b1);
        wait_vld("t3_fixed");
        for (int n = 0; n < 100; n++) begin
            pt = {$urandom(), $urandom()};
            send(enc(pt), pt, 1'b1, 1'b1);
            wait_vld("t3_rand");
        end

        // T4: di_vld held with changing din while busy
        @(negedge clk);
        bus.din    = C_T2_CT;
        bus.di_vld = 1'b1;
        @(posedge clk);
        #1;
        begin
            exp_t e;
            e.pt  = 64'd0;
            e.acc = cyc;
            exp_q.push_back(e);
        end
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                if (bus.do_vld) begin
                    seen       = 1'b1;
                    bus.di_vld = 1'b0;
                end else begin
                    check("t4_busy", 64'(bus.busy), 64'd1);
                    bus.din = {$urandom(), $urandom()};
                end
            end
            check("t4_timeout", 64'(seen), 64'd1);
            check("t4_busy_done", 64'(bus.busy), 64'd0);
        end

        // T5: reset during round i=6, then the standard block again
        pt = 64'h1122334455667788;
        send(enc(pt), pt, 1'b1, 1'b1);
        wait_vld("t5_pre");
        send(C_T2_CT, 64'd0, 1'b1, 1'b0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
        check("t5_dout", bus.dout, 64'd0);
        check("t5_do_vld", 64'(bus.do_vld), 64'd0);
        check("t5_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        clr = 1'b1;
        send(C_T2_CT, 64'd0, 1'b1, 1'b1);
        wait_vld("t5_post");

        // T6: back-to-back acceptance in the first READY cycle
        pt  = 64'hCAFEF00DDEADBEEF;
        pt2 = 64'h0F1E2D3C4B5A6978;
        send(enc(pt), pt, 1'b1, 1'b1);
        wait_vld("t6_first");
        send(enc(pt2), pt2, 1'b0, 1'b1);
        check("t6_do_vld_drop", 64'(bus.do_vld), 64'd0);
        check("t6_busy", 64'(bus.busy), 64'd1);
        check("t6_dout_hold", bus.dout, pt);
        repeat (6) @(negedge clk);
        check("t6_dout_hold_mid", bus.dout, pt);
        wait_vld("t6_second");

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
